// File: rtl/coin_stream_if.sv
// rtl/coin_stream_if.sv - coin code stream from the acceptor to the vending FSM
interface coin_stream_if;
    logic [1:0] data;
    logic       hold;

    modport master (output data, input hold);
    modport slave  (input data, output hold);
endinterface

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces two coin sensors, queues coins, emits paced 2-bit codes
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_a,
    input  logic               coin_b,
    input  logic               clr_ovf,
    coin_stream_if.master      stream,
    output logic               fifo_full,
    output logic               ovf,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {WAIT_LOW, ARMED, CNT_HI, QUAL} deb_state_t;

    logic [1:0]       r_sync1, r_sync2;
    logic [1:0]       w_qual, w_grant;
    logic             r_pend;
    logic             w_push, w_pop, w_accept, w_drop, w_empty, w_full;
    logic [1:0]       w_push_code;
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic [1:0]       r_mem [FIFO_DEPTH];
    logic [GAP_W-1:0] r_gap;
    logic [1:0]       r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {coin_b, coin_a};
            r_sync2 <= r_sync1;
        end
    end

    // Index 0 is the 1-unit sensor, index 1 the 2-unit sensor.
    for (genvar g = 0; g < 2; g++) begin : g_deb
        deb_state_t       r_state, w_state_nxt;
        logic [DEB_W-1:0] r_cnt, w_cnt_nxt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= WAIT_LOW;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                WAIT_LOW: begin
                    if (r_sync2[g]) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nxt = ARMED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + DEB_ONE;
                    end
                end
                ARMED: begin
                    if (r_sync2[g]) begin
                        w_state_nxt = (DEB_CYCLES == 1) ? QUAL : CNT_HI;
                        w_cnt_nxt   = DEB_ONE;
                    end
                end
                CNT_HI: begin
                    if (!r_sync2[g]) begin
                        w_state_nxt = ARMED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nxt = QUAL;
                    end else begin
                        w_cnt_nxt = r_cnt + DEB_ONE;
                    end
                end
                QUAL: begin
                    if (w_grant[g]) begin
                        w_state_nxt = WAIT_LOW;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = WAIT_LOW;
            endcase
        end

        assign w_qual[g] = (r_state == QUAL);
    end

    // A simultaneous 2-unit coin is parked in r_pend, so both sensors are granted together.
    assign w_grant[0]  = !r_pend && w_qual[0];
    assign w_grant[1]  = !r_pend && w_qual[1];
    assign w_push      = r_pend || w_qual[0] || w_qual[1];
    assign w_push_code = (r_pend || !w_qual[0]) ? 2'b10 : 2'b01;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop    = !w_empty && !stream.hold && (r_gap == '0);
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr[AW-1:0]] <= w_push_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_gap    <= '0;
            r_data   <= 2'b00;
            ovf      <= 1'b0;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            if (r_pend)                       r_pend <= 1'b0;
            else if (w_qual[0] && w_qual[1])  r_pend <= 1'b1;
            if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
            // The gap counts down the 00 cycles being driven after each strobe.
            if (w_pop)              r_gap <= GAP_W'(GAP_CYCLES);
            else if (r_gap != '0)   r_gap <= r_gap - GAP_ONE;
            r_data <= w_pop ? r_mem[r_rd_ptr[AW-1:0]] : 2'b00;
            if (w_drop)        ovf <= 1'b1;
            else if (clr_ovf)  ovf <= 1'b0;
            if (w_accept && w_push_code == 2'b01 && cnt_a != '1) cnt_a <= cnt_a + CNT_ONE;
            if (w_accept && w_push_code == 2'b10 && cnt_b != '1) cnt_b <= cnt_b + CNT_ONE;
        end
    end

    assign stream.data = r_data;
    assign fifo_full   = w_full;
endmodule
